// File: rtl/data_mem_responder.sv
// Data-port responder: word RAM behind a valid/ready handshake with RV32 lane steering,
// programmable wait states and error flagging. Optional MMIO LED register: DATA_MEM_RESPONDER_MMIO_LED_EN.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] led_mmio
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : {CNT_W{1'b0}};
    localparam logic [29:0]      DEPTH_IDX = 30'(DEPTH_WORDS);
    localparam logic [29:0]      MMIO_WIDX = 30'h3FFF_C000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    function automatic logic access_err(input logic we, input logic [1:0] lo, input logic [2:0] f3);
        case (f3)
            3'b000:  access_err = 1'b0;
            3'b001:  access_err = lo[0];
            3'b010:  access_err = (lo != 2'b00);
            3'b100:  access_err = we;
            3'b101:  access_err = we | lo[0];
            default: access_err = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] lo, input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'h00_0000, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b101:  load_ext = {16'h0000, h};
            3'b010:  load_ext = word;
            default: load_ext = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [1:0] lo, input logic [2:0] f3);
        logic [31:0] w;
        w = old;
        case (f3)
            3'b000:  w[{lo, 3'b000} +: 8]        = wdata[7:0];
            3'b001:  w[{lo[1], 4'b0000} +: 16]   = wdata[15:0];
            3'b010:  w                           = wdata;
            default: w                           = old;
        endcase
        return w;
    endfunction

    logic [31:0] mem_q [DEPTH_WORDS] = '{default: 32'h0000_0000};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [2:0]       f3_q, f3_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;

    logic             cur_we_s;
    logic [31:0]      cur_addr_s;
    logic [31:0]      cur_wdata_s;
    logic [2:0]       cur_f3_s;
    logic [IDX_W-1:0] idx_s;
    logic             in_ram_s;
    logic             is_mmio_s;
    logic [31:0]      mmio_word_s;
    logic [31:0]      old_word_s;
    logic [31:0]      merged_s;
    logic [31:0]      load_data_s;
    logic             err_s;
    logic             commit_s;
    logic             mem_we_s;

    // The commit may happen straight from IDLE (no wait states), so decode the live request there.
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_we_s    = req_we;
            cur_addr_s  = req_addr;
            cur_wdata_s = req_wdata;
            cur_f3_s    = req_funct3;
        end else begin
            cur_we_s    = we_q;
            cur_addr_s  = addr_q;
            cur_wdata_s = wdata_q;
            cur_f3_s    = f3_q;
        end
    end

`ifdef DATA_MEM_RESPONDER_MMIO_LED_EN
    logic [15:0] led_q, led_d;

    assign is_mmio_s   = (cur_addr_s[31:2] == MMIO_WIDX);
    assign mmio_word_s = {16'h0000, led_q};
    assign led_mmio    = led_q;

    // LED register takes the low half of a committed, error-free MMIO store.
    always_comb begin
        led_d = led_q;
        if (commit_s && cur_we_s && is_mmio_s && !err_s) begin
            led_d = merged_s[15:0];
        end else begin
            led_d = led_q;
        end
    end

    // LED register flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= 16'h0000;
        end else begin
            led_q <= led_d;
        end
    end
`else
    assign is_mmio_s   = 1'b0;
    assign mmio_word_s = 32'h0000_0000;
    assign led_mmio    = 16'h0000;
`endif

    assign idx_s       = cur_addr_s[IDX_W+1:2];
    assign in_ram_s    = (cur_addr_s[31:2] < DEPTH_IDX);
    assign err_s       = access_err(cur_we_s, cur_addr_s[1:0], cur_f3_s) | ~(in_ram_s | is_mmio_s);
    assign old_word_s  = is_mmio_s ? mmio_word_s : mem_q[idx_s];
    assign merged_s    = store_merge(old_word_s, cur_wdata_s, cur_addr_s[1:0], cur_f3_s);
    assign load_data_s = load_ext(old_word_s, cur_addr_s[1:0], cur_f3_s);
    assign mem_we_s    = commit_s && cur_we_s && !err_s && !is_mmio_s;

    // FSM next state, request capture and response registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        commit_s    = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    f3_d    = req_funct3;
                    cnt_d   = {CNT_W{1'b0}};
                    if (WAIT_CYCLES == 0) begin
                        commit_s = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        state_d  = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    commit_s = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit_s) begin
            rsp_err_d   = err_s;
            rsp_rdata_d = (err_s || cur_we_s) ? 32'h0000_0000 : load_data_s;
        end else begin
            rsp_err_d   = rsp_err_q;
            rsp_rdata_d = rsp_rdata_q;
        end

        rsp_valid_d = (state_d == S_RESP);
        req_ready_d = (state_d == S_IDLE);
    end

    // Control and response flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            we_q        <= 1'b0;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            f3_q        <= 3'b000;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // RAM write port; a reset on the commit edge suppresses the store.
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_q[idx_s] <= merged_s;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder, run with WAIT_CYCLES=3.
module tb_data_mem_responder;

    localparam int W = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] led_mmio;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] rd;
        logic        err;
    } op_t;

    exp_t sb_q[$];

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .led_mmio(led_mmio)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] f3, output int lat, output logic [31:0] rd,
                            output logic er, output int acc);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        acc        = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passes++;
        checks++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); else passes++;
        checks++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err got %b want 0", rsp_err); else passes++;
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else passes++;
        checks++; if (led_mmio !== 16'h0) $display("FAIL reset_led got %h want 0", led_mmio); else passes++;
    endtask

    task automatic test_load_store();
        op_t ops [0:12];
        int lat, acc;
        logic [31:0] rd;
        logic er;
        exp_t e;
        ops = '{
            '{1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0},
            '{1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0},
            '{1'b1, 32'h13, 32'hAAAAAA80, 3'b000, 32'h0,        1'b0},
            '{1'b0, 32'h13, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0},
            '{1'b0, 32'h13, 32'h0,        3'b100, 32'h00000080, 1'b0},
            '{1'b0, 32'h10, 32'h0,        3'b010, 32'h80ADBEEF, 1'b0},
            '{1'b0, 32'h12, 32'h0,        3'b001, 32'hFFFF80AD, 1'b0},
            '{1'b0, 32'h10, 32'h0,        3'b101, 32'h0000BEEF, 1'b0},
            '{1'b0, 32'h11, 32'h0,        3'b000, 32'hFFFFFFBE, 1'b0},
            '{1'b0, 32'h12, 32'h0,        3'b100, 32'h000000AD, 1'b0},
            '{1'b1, 32'h12, 32'hFFFF1234, 3'b001, 32'h0,        1'b0},
            '{1'b1, 32'h11, 32'h00000055, 3'b000, 32'h0,        1'b0},
            '{1'b0, 32'h10, 32'h0,        3'b010, 32'h123455EF, 1'b0}
        };
        foreach (ops[i]) begin
            sb_q.push_back('{ops[i].rd, ops[i].err});
            send_req(ops[i].we, ops[i].addr, ops[i].wdata, ops[i].f3, lat, rd, er, acc);
            e = sb_q.pop_front();
            checks++; if (lat !== W + 1) $display("FAIL ls_latency op%0d got %0d want %0d", i, lat, W + 1); else passes++;
            checks++; if (rd !== e.rdata) $display("FAIL ls_rdata op%0d got %h want %h", i, rd, e.rdata); else passes++;
            checks++; if (er !== e.err) $display("FAIL ls_err op%0d got %b want %b", i, er, e.err); else passes++;
            finish_rsp();
        end
    endtask

    task automatic test_errors();
        op_t ops [0:14];
        int lat, acc;
        logic [31:0] rd;
        logic er;
        exp_t e;
        ops = '{
            '{1'b0, 32'h11,   32'h0,        3'b001, 32'h0,        1'b1},
            '{1'b0, 32'h13,   32'h0,        3'b101, 32'h0,        1'b1},
            '{1'b1, 32'h12,   32'hFFFFFFFF, 3'b010, 32'h0,        1'b1},
            '{1'b1, 32'h11,   32'hFFFFFFFF, 3'b001, 32'h0,        1'b1},
            '{1'b0, 32'h10,   32'h0,        3'b011, 32'h0,        1'b1},
            '{1'b0, 32'h10,   32'h0,        3'b110, 32'h0,        1'b1},
            '{1'b0, 32'h10,   32'h0,        3'b111, 32'h0,        1'b1},
            '{1'b1, 32'h10,   32'hFFFFFFFF, 3'b100, 32'h0,        1'b1},
            '{1'b1, 32'h10,   32'hFFFFFFFF, 3'b011, 32'h0,        1'b1},
            '{1'b0, 32'h1000, 32'h0,        3'b010, 32'h0,        1'b1},
            '{1'b1, 32'h1000, 32'hFFFFFFFF, 3'b010, 32'h0,        1'b1},
            '{1'b0, 32'h10,   32'h0,        3'b010, 32'h123455EF, 1'b0},
            '{1'b0, 32'hFFC,  32'h0,        3'b010, 32'h0,        1'b0},
            '{1'b1, 32'hFFC,  32'h00000077, 3'b010, 32'h0,        1'b0},
            '{1'b0, 32'hFFC,  32'h0,        3'b010, 32'h00000077, 1'b0}
        };
        foreach (ops[i]) begin
            sb_q.push_back('{ops[i].rd, ops[i].err});
            send_req(ops[i].we, ops[i].addr, ops[i].wdata, ops[i].f3, lat, rd, er, acc);
            e = sb_q.pop_front();
            checks++; if (lat !== W + 1) $display("FAIL err_latency op%0d got %0d want %0d", i, lat, W + 1); else passes++;
            checks++; if (rd !== e.rdata) $display("FAIL err_rdata op%0d got %h want %h", i, rd, e.rdata); else passes++;
            checks++; if (er !== e.err) $display("FAIL err_flag op%0d got %b want %b", i, er, e.err); else passes++;
            finish_rsp();
        end
    endtask

    task automatic test_backpressure();
        int lat, acc;
        logic [31:0] rd;
        logic er;
        exp_t e;
        sb_q.push_back('{32'h123455EF, 1'b0});
        send_req(1'b0, 32'h10, 32'h0, 3'b010, lat, rd, er, acc);
        e = sb_q.pop_front();
        checks++; if (rd !== e.rdata) $display("FAIL bp_rdata got %h want %h", rd, e.rdata); else passes++;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_hold_valid cyc%0d got %b want 1", k, rsp_valid); else passes++;
            checks++; if (rsp_rdata !== e.rdata) $display("FAIL bp_hold_rdata cyc%0d got %h want %h", k, rsp_rdata, e.rdata); else passes++;
            checks++; if (req_ready !== 1'b0) $display("FAIL bp_hold_ready cyc%0d got %b want 0", k, req_ready); else passes++;
        end
        finish_rsp();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", rsp_valid); else passes++;
        checks++; if (req_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", req_ready); else passes++;
    endtask

    task automatic test_back_to_back();
        int lat, acc1, acc2;
        logic [31:0] rd;
        logic er;
        exp_t e;
        sb_q.push_back('{32'h123455EF, 1'b0});
        sb_q.push_back('{32'h00000077, 1'b0});
        send_req(1'b0, 32'h10, 32'h0, 3'b010, lat, rd, er, acc1);
        e = sb_q.pop_front();
        checks++; if (rd !== e.rdata) $display("FAIL b2b_first got %h want %h", rd, e.rdata); else passes++;
        finish_rsp();
        send_req(1'b0, 32'hFFC, 32'h0, 3'b010, lat, rd, er, acc2);
        e = sb_q.pop_front();
        checks++; if (rd !== e.rdata) $display("FAIL b2b_second got %h want %h", rd, e.rdata); else passes++;
        checks++; if (acc2 - acc1 !== W + 2) $display("FAIL b2b_spacing got %0d want %0d", acc2 - acc1, W + 2); else passes++;
        finish_rsp();
    endtask

    task automatic test_reset_mid();
        int lat, acc;
        logic [31:0] rd;
        logic er;
        exp_t e;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h20;
        req_wdata  = 32'h12345678;
        req_funct3 = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL rm_valid got %b want 0", rsp_valid); else passes++;
        checks++; if (rsp_rdata !== 32'h0) $display("FAIL rm_rdata got %h want 0", rsp_rdata); else passes++;
        checks++; if (rsp_err !== 1'b0) $display("FAIL rm_err got %b want 0", rsp_err); else passes++;
        checks++; if (req_ready !== 1'b1) $display("FAIL rm_ready got %b want 1", req_ready); else passes++;
        sb_q.push_back('{32'h0, 1'b0});
        send_req(1'b0, 32'h20, 32'h0, 3'b010, lat, rd, er, acc);
        e = sb_q.pop_front();
        checks++; if (rd !== e.rdata) $display("FAIL rm_no_write got %h want %h", rd, e.rdata); else passes++;
        finish_rsp();
    endtask

    task automatic test_mmio();
        op_t ops [0:4];
        int lat, acc;
        logic [31:0] rd;
        logic er;
        logic [15:0] led_exp;
        exp_t e;
`ifdef DATA_MEM_RESPONDER_MMIO_LED_EN
        ops = '{
            '{1'b1, 32'hFFFF0000, 32'hFFFFA5C3, 3'b001, 32'h0,        1'b0},
            '{1'b0, 32'hFFFF0000, 32'h0,        3'b101, 32'h0000A5C3, 1'b0},
            '{1'b0, 32'hFFFF0001, 32'h0,        3'b000, 32'hFFFFFFA5, 1'b0},
            '{1'b1, 32'hFFFF0003, 32'h0000005A, 3'b000, 32'h0,        1'b0},
            '{1'b0, 32'hFFFF0000, 32'h0,        3'b010, 32'h0000A5C3, 1'b0}
        };
        led_exp = 16'hA5C3;
`else
        ops = '{
            '{1'b1, 32'hFFFF0000, 32'hFFFFA5C3, 3'b001, 32'h0, 1'b1},
            '{1'b0, 32'hFFFF0000, 32'h0,        3'b101, 32'h0, 1'b1},
            '{1'b0, 32'hFFFF0001, 32'h0,        3'b000, 32'h0, 1'b1},
            '{1'b1, 32'hFFFF0003, 32'h0000005A, 3'b000, 32'h0, 1'b1},
            '{1'b0, 32'hFFFF0000, 32'h0,        3'b010, 32'h0, 1'b1}
        };
        led_exp = 16'h0000;
`endif
        foreach (ops[i]) begin
            sb_q.push_back('{ops[i].rd, ops[i].err});
            send_req(ops[i].we, ops[i].addr, ops[i].wdata, ops[i].f3, lat, rd, er, acc);
            e = sb_q.pop_front();
            checks++; if (rd !== e.rdata) $display("FAIL mmio_rdata op%0d got %h want %h", i, rd, e.rdata); else passes++;
            checks++; if (er !== e.err) $display("FAIL mmio_err op%0d got %b want %b", i, er, e.err); else passes++;
            finish_rsp();
            checks++; if (led_mmio !== led_exp) $display("FAIL mmio_led op%0d got %h want %h", i, led_mmio, led_exp); else passes++;
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_funct3 = 3'b000;
        rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_load_store();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_mmio();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
